// File: rtl/dnn2ami_traffic_checker.sv
// dnn2ami_traffic_checker
// Stands in for the outbuf/inbuf on DNN2AMI's PU side. It writes a known
// pattern out of one modelled outbuf slice, reads the same region back,
// and checks every returned word. The result can be read out on an FPGA
// as easily as in simulation.
module dnn2ami_traffic_checker #(
    parameter int DATA_WIDTH   = 64,
    parameter int NUM_PU       = 2,
    parameter int PU_ID_WIDTH  = 2,
    parameter int ADDR_WIDTH   = 32,
    parameter int SIZE_WIDTH   = 10,
    parameter int STALL_PERIOD = 0,
    parameter int FULL_PERIOD  = 0,
    parameter int TIMEOUT      = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [PU_ID_WIDTH-1:0]         cfg_pu_id,
    input  logic [SIZE_WIDTH-1:0]          cfg_size,
    input  logic [ADDR_WIDTH-1:0]          cfg_addr,
    output logic                           wr_req,
    output logic [PU_ID_WIDTH-1:0]         wr_pu_id,
    output logic [SIZE_WIDTH-1:0]          wr_req_size,
    output logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic                           wr_ready,
    input  logic                           wr_done,
    output logic [NUM_PU-1:0]              outbuf_empty,
    output logic [NUM_PU*DATA_WIDTH-1:0]   data_from_outbuf,
    output logic [NUM_PU-1:0]              write_valid,
    input  logic [NUM_PU-1:0]              outbuf_pop,
    output logic                           rd_req,
    output logic [SIZE_WIDTH-1:0]          rd_req_size,
    output logic [ADDR_WIDTH-1:0]          rd_addr,
    input  logic                           rd_ready,
    input  logic [DATA_WIDTH-1:0]          data_to_inbuf,
    input  logic                           inbuf_push,
    output logic                           inbuf_full,
    output logic                           busy,
    output logic                           done,
    output logic                           pass,
    output logic                           timeout,
    output logic [15:0]                    err_count,
    output logic [SIZE_WIDTH-1:0]          words_checked
);

    localparam int BEAT_SHIFT = $clog2(DATA_WIDTH / 8);
    localparam int INC_W      = $clog2(NUM_PU + 3) + 1;
    localparam int STALL_W    = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    localparam int FULL_W     = (FULL_PERIOD > 1) ? $clog2(FULL_PERIOD) : 1;
    localparam int TMO_W      = $clog2(TIMEOUT + 1) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_WAIT,
        S_RD_REQ,
        S_RD_WAIT,
        S_DONE
    } state_t;

    state_t                  state;
    logic [PU_ID_WIDTH-1:0]  cfg_pu_q;
    logic [SIZE_WIDTH-1:0]   cfg_size_q;
    logic [ADDR_WIDTH-1:0]   cfg_addr_q;
    logic [SIZE_WIDTH-1:0]   beats_q;
    logic [SIZE_WIDTH-1:0]   wr_pops;
    logic [15:0]             base_k;
    logic [TMO_W-1:0]        prog_cnt;

    logic [15:0]             k      [NUM_PU];
    logic [15:0]             k_next [NUM_PU];
    logic [NUM_PU-1:0]       pop_ok;
    logic                    sel_pop;
    logic [15:0]             start_k;
    logic [SIZE_WIDTH-1:0]   start_beats;
    logic [DATA_WIDTH-1:0]   exp_word;
    logic [INC_W-1:0]        err_inc;
    logic [16:0]             err_sum;
    logic [15:0]             err_sat;
    logic                    progress;

    // Word k of slice pu: PU index in the upper bits, a fixed marker, then k.
    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [31:0] pu, input logic [15:0] kk);
        logic [DATA_WIDTH-1:0] w;
        w = '0;
        w[DATA_WIDTH-1:32] = (DATA_WIDTH - 32)'(pu);
        w[31:16] = 16'hAAAA;
        w[15:0] = kk;
        return w;
    endfunction

    assign write_valid = ~outbuf_empty;
    assign pop_ok      = outbuf_pop & ~outbuf_empty;
    assign wr_pu_id    = cfg_pu_q;
    assign wr_req_size = cfg_size_q;
    assign wr_addr     = cfg_addr_q;
    assign rd_req_size = cfg_size_q;
    assign rd_addr     = cfg_addr_q;
    assign pass        = done & ~timeout & (err_count == 16'd0);
    assign start_beats = cfg_size >> BEAT_SHIFT;
    assign exp_word    = pattern(32'(cfg_pu_q), base_k + 16'(words_checked));
    assign progress    = (wr_req & wr_ready) | (rd_req & rd_ready) | (|outbuf_pop) | inbuf_push;

    generate
        if (STALL_PERIOD == 0) begin : g_no_stall
            assign outbuf_empty = '0;
        end else begin : g_stall
            logic [STALL_W-1:0] stall_cnt [NUM_PU];
            // Each slice runs its own period counter, staggered by slice index, and goes empty once per period.
            always_ff @(posedge clk) begin
                for (int p = 0; p < NUM_PU; p++) begin
                    if (rst) begin
                        stall_cnt[p]    <= STALL_W'(p % STALL_PERIOD);
                        outbuf_empty[p] <= 1'b0;
                    end else begin
                        stall_cnt[p]    <= (stall_cnt[p] == STALL_W'(STALL_PERIOD - 1)) ? '0 : stall_cnt[p] + 1'b1;
                        outbuf_empty[p] <= (stall_cnt[p] == STALL_W'(STALL_PERIOD - 1));
                    end
                end
            end
        end

        if (FULL_PERIOD == 0) begin : g_no_full
            assign inbuf_full = 1'b0;
        end else begin : g_full
            logic [FULL_W-1:0] full_cnt;
            // Inbuf back-pressure: full for one cycle in every period.
            always_ff @(posedge clk) begin
                if (rst) begin
                    full_cnt   <= '0;
                    inbuf_full <= 1'b0;
                end else begin
                    full_cnt   <= (full_cnt == FULL_W'(FULL_PERIOD - 1)) ? '0 : full_cnt + 1'b1;
                    inbuf_full <= (full_cnt == FULL_W'(FULL_PERIOD - 1));
                end
            end
        end
    endgenerate

    // Next pattern index per slice, the configured slice's pop, and the index to latch at start.
    always_comb begin
        sel_pop = 1'b0;
        start_k = '0;
        for (int p = 0; p < NUM_PU; p++) begin
            k_next[p] = k[p] + {15'd0, pop_ok[p]};
            if (PU_ID_WIDTH'(p) == cfg_pu_q) begin
                sel_pop = pop_ok[p];
            end
            if (PU_ID_WIDTH'(p) == cfg_pu_id) begin
                start_k = k[p];
            end
        end
    end

    // Pattern counters and the registered outbuf data; data tracks the post-pop index.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PU; p++) begin
            if (rst) begin
                k[p] <= '0;
                data_from_outbuf[p*DATA_WIDTH +: DATA_WIDTH] <= '0;
            end else begin
                k[p] <= k_next[p];
                data_from_outbuf[p*DATA_WIDTH +: DATA_WIDTH] <= pattern(32'(p), k_next[p]);
            end
        end
    end

    // Errors raised this cycle: bad pops, read-data mismatches, overflows and stray pushes.
    always_comb begin
        err_inc = '0;
        if (state != S_IDLE) begin
            for (int p = 0; p < NUM_PU; p++) begin
                if (outbuf_pop[p] && (outbuf_empty[p] || (busy && PU_ID_WIDTH'(p) != cfg_pu_q))) begin
                    err_inc = err_inc + INC_W'(1);
                end
            end
            if (inbuf_push) begin
                if (state == S_RD_WAIT) begin
                    if (data_to_inbuf != exp_word) begin
                        err_inc = err_inc + INC_W'(1);
                    end
                    if (inbuf_full) begin
                        err_inc = err_inc + INC_W'(1);
                    end
                end else begin
                    err_inc = err_inc + INC_W'(1);
                end
            end
        end
        err_sum = {1'b0, err_count} + 17'(err_inc);
        err_sat = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    // Test sequencer: write request, wait for the pops, read request, check pushes, report.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cfg_pu_q      <= '0;
            cfg_size_q    <= '0;
            cfg_addr_q    <= '0;
            beats_q       <= '0;
            wr_pops       <= '0;
            base_k        <= '0;
            prog_cnt      <= '0;
            wr_req        <= 1'b0;
            rd_req        <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            timeout       <= 1'b0;
            err_count     <= '0;
            words_checked <= '0;
        end else begin
            err_count <= err_sat;
            if ((state == S_WR_REQ || state == S_WR_WAIT) && sel_pop && wr_pops != beats_q) begin
                wr_pops <= wr_pops + 1'b1;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        cfg_pu_q      <= cfg_pu_id;
                        cfg_size_q    <= cfg_size;
                        cfg_addr_q    <= cfg_addr;
                        beats_q       <= start_beats;
                        base_k        <= start_k;
                        wr_pops       <= '0;
                        prog_cnt      <= '0;
                        err_count     <= '0;
                        words_checked <= '0;
                        timeout       <= 1'b0;
                        if (start_beats == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state  <= S_WR_REQ;
                            done   <= 1'b0;
                            busy   <= 1'b1;
                            wr_req <= 1'b1;
                        end
                    end
                end
                S_WR_REQ: begin
                    if (wr_ready) begin
                        wr_req <= 1'b0;
                        state  <= S_WR_WAIT;
                    end
                end
                S_WR_WAIT: begin
                    if (wr_pops == beats_q && wr_done) begin
                        rd_req <= 1'b1;
                        state  <= S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    if (rd_ready) begin
                        rd_req <= 1'b0;
                        state  <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (inbuf_push) begin
                        words_checked <= words_checked + 1'b1;
                        if (words_checked + 1'b1 == beats_q) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (busy) begin
                if (progress) begin
                    prog_cnt <= '0;
                end else if (prog_cnt == TMO_W'(TIMEOUT - 1)) begin
                    timeout <= 1'b1;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    wr_req  <= 1'b0;
                    rd_req  <= 1'b0;
                    state   <= S_DONE;
                end else begin
                    prog_cnt <= prog_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dnn2ami_traffic_checker.sv
// Bench for dnn2ami_traffic_checker: plays the DNN2AMI side (handshakes,
// pops into a small memory, pushes the memory back) and scores popped
// words and per-test results against hand-computed values.
module tb_dnn2ami_traffic_checker;

    localparam int DW   = 64;
    localparam int NPU  = 4;
    localparam int PIDW = 2;
    localparam int AW   = 32;
    localparam int SW   = 10;

    typedef struct packed {
        logic        pass;
        logic        timeout;
        logic [15:0] err;
        logic [9:0]  wc;
    } res_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [PIDW-1:0]   cfg_pu_id;
    logic [SW-1:0]     cfg_size;
    logic [AW-1:0]     cfg_addr;
    logic              wr_req;
    logic [PIDW-1:0]   wr_pu_id;
    logic [SW-1:0]     wr_req_size;
    logic [AW-1:0]     wr_addr;
    logic              wr_ready;
    logic              wr_done;
    logic [NPU-1:0]    outbuf_empty;
    logic [NPU*DW-1:0] data_from_outbuf;
    logic [NPU-1:0]    write_valid;
    logic [NPU-1:0]    outbuf_pop;
    logic              rd_req;
    logic [SW-1:0]     rd_req_size;
    logic [AW-1:0]     rd_addr;
    logic              rd_ready;
    logic [DW-1:0]     data_to_inbuf;
    logic              inbuf_push;
    logic              inbuf_full;
    logic              busy;
    logic              done;
    logic              pass;
    logic              timeout;
    logic [15:0]       err_count;
    logic [SW-1:0]     words_checked;

    logic [DW-1:0] exp_word_q[$];
    res_t          exp_res_q[$];
    int            compared   = 0;
    int            mismatched = 0;
    int            active_pu  = 0;
    logic          done_prev  = 1'b0;

    always #5 clk = ~clk;

    dnn2ami_traffic_checker #(
        .DATA_WIDTH(DW), .NUM_PU(NPU), .PU_ID_WIDTH(PIDW), .ADDR_WIDTH(AW),
        .SIZE_WIDTH(SW), .STALL_PERIOD(3), .FULL_PERIOD(4), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_pu_id(cfg_pu_id),
        .cfg_size(cfg_size), .cfg_addr(cfg_addr), .wr_req(wr_req),
        .wr_pu_id(wr_pu_id), .wr_req_size(wr_req_size), .wr_addr(wr_addr),
        .wr_ready(wr_ready), .wr_done(wr_done), .outbuf_empty(outbuf_empty),
        .data_from_outbuf(data_from_outbuf), .write_valid(write_valid),
        .outbuf_pop(outbuf_pop), .rd_req(rd_req), .rd_req_size(rd_req_size),
        .rd_addr(rd_addr), .rd_ready(rd_ready), .data_to_inbuf(data_to_inbuf),
        .inbuf_push(inbuf_push), .inbuf_full(inbuf_full), .busy(busy),
        .done(done), .pass(pass), .timeout(timeout), .err_count(err_count),
        .words_checked(words_checked)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic waitExpired(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: wait bound expired, got no event, expected one", name);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_wr_req"}, 256'(wr_req), 256'(0));
        checkOutput({tag, "_rd_req"}, 256'(rd_req), 256'(0));
        checkOutput({tag, "_busy"}, 256'(busy), 256'(0));
        checkOutput({tag, "_done"}, 256'(done), 256'(0));
        checkOutput({tag, "_pass"}, 256'(pass), 256'(0));
        checkOutput({tag, "_timeout"}, 256'(timeout), 256'(0));
        checkOutput({tag, "_err_count"}, 256'(err_count), 256'(0));
        checkOutput({tag, "_words_checked"}, 256'(words_checked), 256'(0));
        checkOutput({tag, "_outbuf_empty"}, 256'(outbuf_empty), 256'(0));
        checkOutput({tag, "_write_valid"}, 256'(write_valid), 256'(4'hF));
        checkOutput({tag, "_inbuf_full"}, 256'(inbuf_full), 256'(0));
        checkOutput({tag, "_data_from_outbuf"}, data_from_outbuf, 256'(0));
        checkOutput({tag, "_addr"}, 256'({wr_addr, rd_addr, wr_req_size, rd_req_size, wr_pu_id}), 256'(0));
    endtask

    // Compare popped outbuf data on the active slice and each finished test's result.
    always @(negedge clk) begin
        if (!rst) begin
            for (int p = 0; p < NPU; p++) begin
                if (outbuf_pop[p] && !outbuf_empty[p] && p == active_pu) begin
                    if (exp_word_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("[TB] FAIL unexpected_pop: got a pop on slice %0d, expected none", p);
                    end else begin
                        checkOutput("pop_data", 256'(data_from_outbuf[p*DW +: DW]), 256'(exp_word_q.pop_front()));
                    end
                end
            end
            if (done && !done_prev) begin
                if (exp_res_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_done: got done, expected no result");
                end else begin
                    res_t r;
                    r = exp_res_q.pop_front();
                    checkOutput("res_pass", 256'(pass), 256'(r.pass));
                    checkOutput("res_timeout", 256'(timeout), 256'(r.timeout));
                    checkOutput("res_err_count", 256'(err_count), 256'(r.err));
                    checkOutput("res_words_checked", 256'(words_checked), 256'(r.wc));
                end
            end
        end
        done_prev = done;
    end

    task automatic applyStimulus(input int pu, input int size, input int beats, input int corrupt_idx,
                                 input bit stray, input bit push_full, input bit no_wr_ready, input bit abort_rd);
        logic [DW-1:0] mem[$];
        int n;
        int g;
        active_pu = pu;
        cfg_pu_id = PIDW'(pu);
        cfg_size  = SW'(size);
        cfg_addr  = 32'h1000 + 32'(pu * 256);
        wr_done   = 1'b0;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        if (no_wr_ready) begin
            checkOutput("wr_req_held", 256'(wr_req), 256'(1));
            n = 0;
            while (!done && n < 40) begin
                tick();
                n++;
            end
            checkOutput("timeout_latency_ok", 256'(n >= 16 && n <= 18), 256'(1));
            wr_done = 1'b1;
            return;
        end
        if (beats > 0) begin
            checkOutput("wr_req", 256'(wr_req), 256'(1));
            checkOutput("wr_req_size", 256'(wr_req_size), 256'(size));
            checkOutput("wr_addr", 256'(wr_addr), 256'(32'h1000 + 32'(pu * 256)));
            wr_ready = 1'b1;
            tick();
            wr_ready = 1'b0;
            n = 0;
            g = 0;
            while (n < beats && g < 200) begin
                outbuf_pop = '0;
                if (!outbuf_empty[pu]) begin
                    outbuf_pop[pu] = 1'b1;
                    mem.push_back(data_from_outbuf[pu*DW +: DW]);
                    n++;
                end
                tick();
                g++;
            end
            outbuf_pop = '0;
            if (n < beats) waitExpired("pop_phase");
            if (stray) begin
                g = 0;
                while (outbuf_empty[0] && g < 10) begin tick(); g++; end
                outbuf_pop[0] = 1'b1;
                tick();
                outbuf_pop = '0;
                g = 0;
                while (!outbuf_empty[2] && g < 10) begin tick(); g++; end
                outbuf_pop[2] = 1'b1;
                tick();
                outbuf_pop = '0;
            end
            wr_done = 1'b1;
            g = 0;
            while (!rd_req && g < 50) begin tick(); g++; end
            if (!rd_req) waitExpired("rd_req");
            checkOutput("rd_addr", 256'(rd_addr), 256'(32'h1000 + 32'(pu * 256)));
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
            for (int i = 0; i < beats && i < mem.size(); i++) begin
                g = 0;
                while ((push_full ? !inbuf_full : inbuf_full) && g < 10) begin tick(); g++; end
                inbuf_push    = 1'b1;
                data_to_inbuf = mem[i] ^ ((i == corrupt_idx) ? 64'd1 : 64'd0);
                tick();
                inbuf_push    = 1'b0;
                if (abort_rd) begin
                    rst = 1'b1;
                    tick();
                    tick();
                    checkReset("midtest_rst");
                    rst = 1'b0;
                    tick();
                    return;
                end
            end
        end
        g = 0;
        while (!done && g < 100) begin tick(); g++; end
        if (!done) waitExpired("done");
        tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg_pu_id = '0; cfg_size = '0; cfg_addr = '0;
        wr_ready = 1'b0; wr_done = 1'b1; outbuf_pop = '0; rd_ready = 1'b0;
        data_to_inbuf = '0; inbuf_push = 1'b0;
        repeat (3) tick();
        checkReset("por");
        rst = 1'b0;
        tick();

        $display("[TB] test 1: ideal write/read-back on PU 1");
        for (int i = 0; i < 4; i++) exp_word_q.push_back(64'h0000_0001_AAAA_0000 + 64'(i));
        exp_res_q.push_back('{1'b1, 1'b0, 16'd0, 10'd4});
        applyStimulus(1, 32, 4, -1, 0, 0, 0, 0);

        $display("[TB] test 2: corrupted 3rd read word");
        for (int i = 0; i < 4; i++) exp_word_q.push_back(64'h0000_0001_AAAA_0004 + 64'(i));
        exp_res_q.push_back('{1'b0, 1'b0, 16'd1, 10'd4});
        applyStimulus(1, 32, 4, 2, 0, 0, 0, 0);

        $display("[TB] test 3: back-to-back on PU 0");
        for (int i = 0; i < 2; i++) exp_word_q.push_back(64'h0000_0000_AAAA_0000 + 64'(i));
        exp_res_q.push_back('{1'b1, 1'b0, 16'd0, 10'd2});
        applyStimulus(0, 16, 2, -1, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) exp_word_q.push_back(64'h0000_0000_AAAA_0002 + 64'(i));
        exp_res_q.push_back('{1'b1, 1'b0, 16'd0, 10'd2});
        applyStimulus(0, 16, 2, -1, 0, 0, 0, 0);

        $display("[TB] test 4: truncated size on PU 3 with stray and empty pops");
        for (int i = 0; i < 2; i++) exp_word_q.push_back(64'h0000_0003_AAAA_0000 + 64'(i));
        exp_res_q.push_back('{1'b0, 1'b0, 16'd2, 10'd2});
        applyStimulus(3, 20, 2, -1, 1, 0, 0, 0);

        $display("[TB] test 5: push while full, then push while done");
        exp_word_q.push_back(64'h0000_0002_AAAA_0000);
        exp_res_q.push_back('{1'b0, 1'b0, 16'd1, 10'd1});
        applyStimulus(2, 8, 1, -1, 0, 1, 0, 0);
        inbuf_push = 1'b1;
        data_to_inbuf = '0;
        tick();
        inbuf_push = 1'b0;
        checkOutput("err_after_done_push", 256'(err_count), 256'(2));
        checkOutput("pass_after_done_push", 256'(pass), 256'(0));

        $display("[TB] test 6: wr_ready never asserted");
        exp_res_q.push_back('{1'b0, 1'b1, 16'd0, 10'd0});
        applyStimulus(1, 32, 4, -1, 0, 0, 1, 0);
        tick();

        $display("[TB] test 7: reset during read phase");
        for (int i = 0; i < 4; i++) exp_word_q.push_back(64'h0000_0001_AAAA_0008 + 64'(i));
        applyStimulus(1, 32, 4, -1, 0, 0, 0, 1);

        $display("[TB] test 8: zero-beat request");
        exp_res_q.push_back('{1'b1, 1'b0, 16'd0, 10'd0});
        applyStimulus(0, 4, 0, -1, 0, 0, 0, 0);

        $display("[TB] test 9: PU 0 pattern restarts after reset");
        for (int i = 0; i < 2; i++) exp_word_q.push_back(64'h0000_0000_AAAA_0000 + 64'(i));
        exp_res_q.push_back('{1'b1, 1'b0, 16'd0, 10'd2});
        applyStimulus(0, 16, 2, -1, 0, 0, 0, 0);

        repeat (4) tick();
        checkOutput("words_left", 256'(exp_word_q.size()), 256'(0));
        checkOutput("results_left", 256'(exp_res_q.size()), 256'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no end of run, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/dnn2ami_traffic_checker.md
Name: dnn2ami_traffic_checker

Overview:
- Synthesizable, parametrised stimulus and checker for DNN2AMI; sits on DNN2AMI's PU-side read/write ports in place of the outbuf and inbuf.
- Models NUM_PU output-buffer slices with a deterministic data pattern and configurable empty stalls, and models the input buffer with configurable full back-pressure.
- Sequences one write request followed by a read-back of the same region, then checks every pushed read word against the expected pattern.
- Reports pass/fail, error count and timeout, so the same block serves both simulation and on-FPGA regression.

Parameters:
DATA_WIDTH, 64, word width; must be >= 64 and a power of two
NUM_PU, 2, number of modelled outbuf slices
PU_ID_WIDTH, 2, width of wr_pu_id / cfg_pu_id
ADDR_WIDTH, 32, rd/wr address width
SIZE_WIDTH, 10, request size width, in bytes
STALL_PERIOD, 0, 0 = outbuf never empty; N>0 = each slice reports empty one cycle in every N (per-slice free-running counter, offset by PU index)
FULL_PERIOD, 0, 0 = inbuf never full; N>0 = inbuf_full high one cycle in every N
TIMEOUT, 1024, cycles without progress in any wait state before aborting

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  one-cycle pulse, begins a test when idle
cfg_pu_id  in  PU_ID_WIDTH  PU whose data is written, sampled at start
cfg_size  in  SIZE_WIDTH  bytes per request, sampled at start
cfg_addr  in  ADDR_WIDTH  base address, sampled at start
wr_req  out  1  write request
wr_pu_id  out  PU_ID_WIDTH  latched cfg_pu_id
wr_req_size  out  SIZE_WIDTH  latched cfg_size
wr_addr  out  ADDR_WIDTH  latched cfg_addr
wr_ready  in  1  DNN2AMI accepts a write request
wr_done  in  1  DNN2AMI has no writes outstanding
outbuf_empty  out  NUM_PU  per-slice empty
data_from_outbuf  out  NUM_PU*DATA_WIDTH  slice p in bits [(p+1)*DW-1 : p*DW]
write_valid  out  NUM_PU  per-slice valid, equals ~outbuf_empty
outbuf_pop  in  NUM_PU  per-slice dequeue
rd_req  out  1  read request
rd_req_size  out  SIZE_WIDTH  latched cfg_size
rd_addr  out  ADDR_WIDTH  latched cfg_addr
rd_ready  in  1  DNN2AMI accepts a read request
data_to_inbuf  in  DATA_WIDTH  read data
inbuf_push  in  1  read data valid
inbuf_full  out  1  modelled back-pressure
busy  out  1  test in progress
done  out  1  sticky; high once the test ends
pass  out  1  valid when done; 1 iff err_count==0 and timeout==0
timeout  out  1  sticky abort flag
err_count  out  16  mismatches plus protocol errors, saturating
words_checked  out  SIZE_WIDTH  read words compared

Behaviour:
Reset and common rules:
- Reset is rst, synchronous, active-high; clock is clk.
- On reset: every output is 0 except write_valid, which follows ~outbuf_empty; pattern counters, stall/full counters and the FSM all clear (FSM to IDLE).
- Reset mid-test aborts the test and clears the result.

Pattern and pop handling:
- Slice p, word k = {p zero-extended into [DW-1:32], 16'hAAAA in [31:16], k[15:0] in [15:0]}.
- k_p increments on each outbuf_pop[p] while outbuf_empty[p]=0.
- A pop while empty does not advance k_p; it increments err_count (protocol error).
- Simultaneous pops on several slices are each handled independently.

Request sizing:
- beats = cfg_size >> log2(DW/8).
- A non-multiple size truncates the beat count.
- beats==0: the FSM goes straight IDLE->DONE with pass=1.

FSM:
- IDLE: on start, latch the configuration, latch base_k = k[cfg_pu_id], clear err_count, words_checked, done and timeout; go to WR_REQ.
- WR_REQ: assert wr_req (held constant) until the cycle where wr_ready=1; that cycle is the handshake. Next cycle drop wr_req and go to WR_WAIT.
- WR_WAIT: wait until beats pops on cfg_pu_id have been counted AND wr_done=1, then go to RD_REQ.
  - Pops on other slices during the test are protocol errors.
- RD_REQ: same handshake as WR_REQ, using rd_req/rd_ready; then go to RD_WAIT.
- RD_WAIT: each inbuf_push compares data_to_inbuf against pattern(cfg_pu_id, base_k + words_checked).
  - A mismatch increments err_count.
  - words_checked increments on every push.
  - A push while inbuf_full=1 is an overflow error (+1), but the data is still checked.
  - Exit to DONE when words_checked==beats.
  - Extra pushes while DONE count as errors.
- DONE: done=1, busy=0; start re-arms the FSM (same transition as from IDLE).
  - start while busy is ignored.

Timeout:
- A progress counter resets on any handshake, pop or push.
- Reaching TIMEOUT in any non-IDLE, non-DONE state sets timeout=1 and goes to DONE.

Arithmetic:
- k is 16-bit and wraps 0xFFFF->0x0000.
- The expected-word index wraps identically.
- err_count saturates at 0xFFFF.

Test Plan:
1. Ideal memory, STALL_PERIOD=0, FULL_PERIOD=0, start with pu_id=1, size=32, addr=0 -> 4 pops on slice 1 returning 0x00000001AAAA0000..0003, 4 pushes, done=1, pass=1, words_checked=4.
2. STALL_PERIOD=3, same config -> pops only in non-empty cycles, data still 0x..0000..0003, pass=1; no pop while empty is accepted.
3. Force data_to_inbuf bit 0 inverted on the 3rd push -> err_count=1, pass=0, done=1.
4. Hold wr_ready=0 forever, TIMEOUT=16 -> timeout=1 and done=1 at least 16 cycles after the last progress event, pass=0.
5. Back-to-back tests with pu_id=0 and size=16 twice -> second test expects k=2,3, pass=1; assert rst during RD_WAIT -> all outputs 0, busy=0, and the next test starts with k=0.
6. NUM_PU=4, DATA_WIDTH=128, size=64 on pu_id=3 -> 4 beats, slice 3 in bits [511:384], pass=1; a stray pop on slice 0 -> err_count=1.
